uart_tx_ctrl: RTL and testbench
===============================

Name: uart_tx_ctrl

Overview:
Transmit-side controller for the UART TX path. It accepts a parallel byte through a valid/busy handshake and sequences the 4:1 line-select mux through the start, data, parity and stop phases, each lasting one bit period. It also supplies the serialized data bit and the computed parity bit to the mux inputs. It sits between the host-side data source and the registered TX output mux.

Parameters:
DATA_WIDTH, 8, payload bits per frame (LSB first)
CLKS_PER_BIT, 16, clk cycles per UART bit period (>=2)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
p_data  input  DATA_WIDTH  parallel payload
data_valid  input  1  request to send p_data
par_en  input  1  1 = parity bit inserted after the data bits
par_typ  input  1  0 = even, 1 = odd
mux_sel  output  2  line select: 0 start, 1 data, 2 parity, 3 stop/idle
ser_data  output  1  current data bit, routed to mux data input
par_bit  output  1  parity of the latched payload, routed to mux parity input
busy  output  1  frame in progress; data_valid is ignored while high
frame_done  output  1  single-cycle pulse at the end of the stop bit

Behaviour:
- Reset (async, rst=1): state=IDLE, mux_sel=3, ser_data=0, par_bit=0, busy=0, frame_done=0. Bit and baud counters cleared; any frame in flight is abandoned.
- All outputs are registered.
- States and transitions:
  - IDLE: mux_sel=3. Leaves IDLE only on data_valid=1.
  - START: mux_sel=0.
  - DATA: mux_sel=1.
  - PARITY: mux_sel=2.
  - STOP: mux_sel=3.
- Handshake:
  - data_valid is sampled only in IDLE.
  - On the edge where IDLE sees data_valid=1: latch p_data, par_en and par_typ; compute par_bit = ^p_data ^ par_typ; go to START; set busy=1.
  - data_valid while busy=1 is ignored, with no queuing.
  - Config changes mid-frame have no effect.
- Bit timing:
  - A baud counter counts 0..CLKS_PER_BIT-1 in each non-IDLE state. On terminal count, move to the next state and restart at 0.
  - START lasts exactly CLKS_PER_BIT cycles, then goes to DATA.
  - DATA:
    - Bit index 0..DATA_WIDTH-1; each bit lasts CLKS_PER_BIT cycles.
    - ser_data = latched_data[idx], updated on the same edge that advances idx.
    - ser_data = latched_data[0] from entry into START.
    - After the last bit: go to PARITY if latched par_en=1, else STOP.
  - PARITY lasts CLKS_PER_BIT cycles, then goes to STOP.
  - STOP lasts CLKS_PER_BIT cycles, then goes to IDLE.
  - On the STOP→IDLE edge: busy=0 and frame_done=1 for one cycle.
- Frame length from accept edge to busy=0: (2+DATA_WIDTH+par_en)*CLKS_PER_BIT cycles.
- Back-to-back frames: at least one IDLE cycle separates frames. A new frame is accepted on the first IDLE cycle if data_valid=1.
- par_bit holds its value until the next accept. ser_data holds its last value in STOP and IDLE; it is don't-care outside DATA.
- The downstream mux registers its output, so the line lags mux_sel by one clk. This controller does not compensate.
- Widths:
  - Bit index: $clog2(DATA_WIDTH) bits.
  - Baud counter: $clog2(CLKS_PER_BIT) bits.
  - Counter wrap is explicit at terminal count, never natural overflow.

Test Plan:
- Reset release with data_valid=0 -> mux_sel=3, busy=0, frame_done=0 held indefinitely. Assert rst asynchronously mid-cycle -> outputs reach reset values before the next edge.
- CLKS_PER_BIT=4, p_data=8'hA5, par_en=1, par_typ=0 -> mux_sel sequence: 0 x4, 1 x32, 2 x4, 3 x4.
  - ser_data per bit: 1,0,1,0,0,1,0,1.
  - par_bit=0; busy high for 44 cycles; one frame_done pulse.
- Same frame with par_en=0, par_typ=1, p_data=8'h07 -> no mux_sel=2 phase; busy high for 40 cycles. Then send with par_en=1 -> par_bit=0 (odd parity of three ones).
- data_valid held high continuously with p_data changing mid-frame -> first payload is sent intact. The second frame starts on the first IDLE cycle after frame_done, using p_data sampled at that cycle.
- rst pulse during DATA bit 3 -> immediate IDLE, mux_sel=3, busy=0, no frame_done. The next data_valid starts a clean frame from START.
- Scoreboard: a reference UART RX model decodes the mux line output for 200 random bytes, random par_en/par_typ, with CLKS_PER_BIT=16 -> all bytes and parity match, zero framing errors.

Source files
------------

// File: rtl/uart_tx_ctrl_if.sv
// Handshake and line-select bundle between the host data source, the UART TX
// controller and the downstream TX output mux.
`timescale 1ns/1ps

interface uart_tx_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 8
) ();

    logic [DATA_WIDTH-1:0] p_data;
    logic                  data_valid;
    logic                  par_en;
    logic                  par_typ;
    logic [1:0]            mux_sel;
    logic                  ser_data;
    logic                  par_bit;
    logic                  busy;
    logic                  frame_done;

    // Host side: offers a byte and framing config, watches progress.
    modport master (
        output p_data,
        output data_valid,
        output par_en,
        output par_typ,
        input  mux_sel,
        input  ser_data,
        input  par_bit,
        input  busy,
        input  frame_done
    );

    // Controller side.
    modport slave (
        input  p_data,
        input  data_valid,
        input  par_en,
        input  par_typ,
        output mux_sel,
        output ser_data,
        output par_bit,
        output busy,
        output frame_done
    );

endinterface

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: accepts a byte on a valid/busy handshake and walks
// the 4:1 line-select mux through start, data, optional parity and stop bits,
// one bit period each. Supplies the serial data bit and parity bit to the mux.
// Every output comes straight from a flop.
`timescale 1ns/1ps

module uart_tx_ctrl #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic          clk,
    input  logic          rst,
    uart_tx_ctrl_if.slave bus
);

    localparam int unsigned IdxW  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [IdxW-1:0]  IdxLast  = IdxW'(DATA_WIDTH - 1);
    localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);

    // Line-select codes understood by the downstream mux.
    localparam logic [1:0] SelStart  = 2'd0;
    localparam logic [1:0] SelData   = 2'd1;
    localparam logic [1:0] SelParity = 2'd2;
    localparam logic [1:0] SelStop   = 2'd3;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e                state_q, state_d;
    logic [BaudW-1:0]      baud_q, baud_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  par_en_q, par_en_d;
    logic [1:0]            mux_sel_q, mux_sel_d;
    logic                  ser_data_q, ser_data_d;
    logic                  par_bit_q, par_bit_d;
    logic                  busy_q, busy_d;
    logic                  frame_done_q, frame_done_d;

    logic                  baud_tc;
    logic [BaudW-1:0]      baud_inc;
    logic [IdxW-1:0]       idx_inc;

    assign baud_tc  = (baud_q == BaudLast);
    assign baud_inc = baud_q + BaudW'(1);
    assign idx_inc  = idx_q + IdxW'(1);

    // State and output registers; reset abandons any frame in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            baud_q       <= '0;
            idx_q        <= '0;
            data_q       <= '0;
            par_en_q     <= 1'b0;
            mux_sel_q    <= SelStop;
            ser_data_q   <= 1'b0;
            par_bit_q    <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            baud_q       <= baud_d;
            idx_q        <= idx_d;
            data_q       <= data_d;
            par_en_q     <= par_en_d;
            mux_sel_q    <= mux_sel_d;
            ser_data_q   <= ser_data_d;
            par_bit_q    <= par_bit_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Next-state and next-output decode; outputs are computed one edge early so
    // they change together with the state they describe.
    always_comb begin
        state_d      = state_q;
        baud_d       = baud_q;
        idx_d        = idx_q;
        data_d       = data_q;
        par_en_d     = par_en_q;
        mux_sel_d    = mux_sel_q;
        ser_data_d   = ser_data_q;
        par_bit_d    = par_bit_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;

        // The baud counter only runs inside a frame and wraps explicitly.
        if (state_q != StIdle) begin
            baud_d = baud_tc ? '0 : baud_inc;
        end

        unique case (state_q)
            StIdle: begin
                baud_d    = '0;
                idx_d     = '0;
                mux_sel_d = SelStop;
                busy_d    = 1'b0;
                if (bus.data_valid) begin
                    // Snapshot payload and config; later changes cannot reach the frame.
                    data_d     = bus.p_data;
                    par_en_d   = bus.par_en;
                    par_bit_d  = (^bus.p_data) ^ bus.par_typ;
                    ser_data_d = bus.p_data[0];
                    mux_sel_d  = SelStart;
                    busy_d     = 1'b1;
                    state_d    = StStart;
                end
            end

            StStart: begin
                if (baud_tc) begin
                    mux_sel_d = SelData;
                    state_d   = StData;
                end
            end

            StData: begin
                if (baud_tc) begin
                    if (idx_q == IdxLast) begin
                        // ser_data keeps the last bit; it is unused past DATA.
                        idx_d = '0;
                        if (par_en_q) begin
                            mux_sel_d = SelParity;
                            state_d   = StParity;
                        end else begin
                            mux_sel_d = SelStop;
                            state_d   = StStop;
                        end
                    end else begin
                        idx_d      = idx_inc;
                        ser_data_d = data_q[idx_inc];
                    end
                end
            end

            StParity: begin
                if (baud_tc) begin
                    mux_sel_d = SelStop;
                    state_d   = StStop;
                end
            end

            StStop: begin
                if (baud_tc) begin
                    mux_sel_d    = SelStop;
                    busy_d       = 1'b0;
                    frame_done_d = 1'b1;
                    state_d      = StIdle;
                end
            end

            default: begin
                baud_d    = '0;
                idx_d     = '0;
                mux_sel_d = SelStop;
                busy_d    = 1'b0;
                state_d   = StIdle;
            end
        endcase
    end

    assign bus.mux_sel    = mux_sel_q;
    assign bus.ser_data   = ser_data_q;
    assign bus.par_bit    = par_bit_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: directed frame checks on a 4-clock-per-bit instance
// and a random byte stream through a 16-clock-per-bit instance, decoded by a
// simple receiver sampling the registered mux line at bit centres.
`timescale 1ns/1ps

module tb_uart_tx_ctrl;

    localparam int DW = 8;
    localparam int CA = 4;
    localparam int CB = 16;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    uart_tx_ctrl_if #(.DATA_WIDTH(DW)) ia ();
    uart_tx_ctrl_if #(.DATA_WIDTH(DW)) ib ();

    uart_tx_ctrl #(
        .DATA_WIDTH  (DW),
        .CLKS_PER_BIT(CA)
    ) dut_a (
        .clk(clk),
        .rst(rst),
        .bus(ia)
    );

    uart_tx_ctrl #(
        .DATA_WIDTH  (DW),
        .CLKS_PER_BIT(CB)
    ) dut_b (
        .clk(clk),
        .rst(rst),
        .bus(ib)
    );

    int checks = 0;
    int errors = 0;

    // Downstream registered mux for instance B: line lags mux_sel by one clock.
    logic line_b;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_b <= 1'b1;
        end else begin
            case (ib.mux_sel)
                2'd0:    line_b <= 1'b0;
                2'd1:    line_b <= ib.ser_data;
                2'd2:    line_b <= ib.par_bit;
                default: line_b <= 1'b1;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offer a frame on A at a negedge; returns at the negedge after the accept edge.
    task automatic offer_a(input logic [7:0] d, input logic pe, input logic pt);
        ia.p_data     = d;
        ia.par_en     = pe;
        ia.par_typ    = pt;
        ia.data_valid = 1'b1;
        @(negedge clk);
    endtask

    // Checks one frame on A cycle by cycle from the first cycle after the accept
    // edge (k=0) through the frame_done cycle (k=flen). Returns one negedge later.
    task automatic check_frame(input logic [7:0] d, input logic pe, input logic pt,
                               input logic hold, input logic chg,
                               input logic [7:0] nd, input logic npe, input logic npt);
        int   flen;
        int   data_end;
        int   busy_cnt;
        int   done_cnt;
        logic [1:0] exp_mux;
        logic exp_par;
        flen     = (2 + DW + (pe ? 1 : 0)) * CA;
        data_end = (1 + DW) * CA;
        exp_par  = (^d) ^ pt;
        busy_cnt = 0;
        done_cnt = 0;
        for (int k = 0; k <= flen; k++) begin
            if (k < CA)              exp_mux = 2'd0;
            else if (k < data_end)   exp_mux = 2'd1;
            else if (k < flen - CA)  exp_mux = 2'd2;
            else                     exp_mux = 2'd3;
            chk("mux_sel", {30'd0, ia.mux_sel}, {30'd0, exp_mux});
            chk("busy", {31'd0, ia.busy}, {31'd0, (k < flen)});
            chk("frame_done", {31'd0, ia.frame_done}, {31'd0, (k == flen)});
            chk("par_bit", {31'd0, ia.par_bit}, {31'd0, exp_par});
            if (k >= CA && k < data_end) begin
                chk("ser_data", {31'd0, ia.ser_data}, {31'd0, d[(k - CA) / CA]});
            end
            busy_cnt += ia.busy ? 1 : 0;
            done_cnt += ia.frame_done ? 1 : 0;
            if (k == 0 && !hold) ia.data_valid = 1'b0;
            if (k == 10 && chg) begin
                ia.p_data  = nd;
                ia.par_en  = npe;
                ia.par_typ = npt;
            end
            @(negedge clk);
        end
        chk("busy_len", busy_cnt, flen);
        chk("done_pulses", done_cnt, 1);
    endtask

    // One clock on B, scrambling config that must not reach the frame in flight.
    task automatic step_b();
        @(negedge clk);
        ib.p_data  = 8'($urandom);
        ib.par_en  = 1'($urandom);
        ib.par_typ = 1'($urandom);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] d;
        logic       pe;
        logic       pt;
        logic [7:0] rx;
        logic       got;

        rst           = 1'b1;
        ia.p_data     = '0;
        ia.data_valid = 1'b0;
        ia.par_en     = 1'b0;
        ia.par_typ    = 1'b0;
        ib.p_data     = '0;
        ib.data_valid = 1'b0;
        ib.par_en     = 1'b0;
        ib.par_typ    = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_mux_sel", {30'd0, ia.mux_sel}, 32'd3);
        chk("rst_ser_data", {31'd0, ia.ser_data}, 32'd0);
        chk("rst_par_bit", {31'd0, ia.par_bit}, 32'd0);
        chk("rst_busy", {31'd0, ia.busy}, 32'd0);
        chk("rst_frame_done", {31'd0, ia.frame_done}, 32'd0);
        rst = 1'b0;

        // Idle with no request: nothing moves.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("idle_mux_sel", {30'd0, ia.mux_sel}, 32'd3);
            chk("idle_busy", {31'd0, ia.busy}, 32'd0);
            chk("idle_frame_done", {31'd0, ia.frame_done}, 32'd0);
        end

        // Even parity frame.
        offer_a(8'hA5, 1'b1, 1'b0);
        check_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

        // No parity phase, then odd parity of three ones.
        offer_a(8'h07, 1'b0, 1'b1);
        check_frame(8'h07, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        offer_a(8'h07, 1'b1, 1'b1);
        check_frame(8'h07, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

        // data_valid held high with inputs changing mid-frame: first payload intact,
        // second accepted on the first IDLE cycle with the inputs present then.
        offer_a(8'h3C, 1'b1, 1'b1);
        check_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 8'h96, 1'b0, 1'b0);
        check_frame(8'h96, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

        // Asynchronous reset in the middle of DATA bit 3.
        offer_a(8'h5A, 1'b1, 1'b0);
        ia.data_valid = 1'b0;
        repeat (17) @(negedge clk);
        chk("pre_rst_mux_sel", {30'd0, ia.mux_sel}, 32'd1);
        chk("pre_rst_ser_data", {31'd0, ia.ser_data}, 32'd1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_mux_sel", {30'd0, ia.mux_sel}, 32'd3);
        chk("async_rst_busy", {31'd0, ia.busy}, 32'd0);
        chk("async_rst_frame_done", {31'd0, ia.frame_done}, 32'd0);
        chk("async_rst_par_bit", {31'd0, ia.par_bit}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("post_rst_mux_sel", {30'd0, ia.mux_sel}, 32'd3);
            chk("post_rst_busy", {31'd0, ia.busy}, 32'd0);
            chk("post_rst_frame_done", {31'd0, ia.frame_done}, 32'd0);
        end
        offer_a(8'hC3, 1'b1, 1'b1);
        check_frame(8'hC3, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

        // Random byte stream through B, decoded off the registered mux line.
        for (int n = 0; n < 200; n++) begin
            d  = 8'($urandom);
            pe = 1'($urandom);
            pt = 1'($urandom);
            ib.p_data     = d;
            ib.par_en     = pe;
            ib.par_typ    = pt;
            ib.data_valid = 1'b1;
            @(negedge clk);
            ib.data_valid = 1'b0;

            got = 1'b0;
            for (int t = 0; t < 4 * CB && !got; t++) begin
                if (line_b === 1'b0) got = 1'b1;
                else step_b();
            end
            chk("rx_start_seen", {31'd0, got}, 32'd1);
            if (got) begin
                repeat (CB / 2) step_b();
                chk("rx_start_bit", {31'd0, line_b}, 32'd0);
                rx = '0;
                for (int i = 0; i < DW; i++) begin
                    repeat (CB) step_b();
                    rx[i] = line_b;
                end
                chk("rx_data", {24'd0, rx}, {24'd0, d});
                if (pe) begin
                    repeat (CB) step_b();
                    chk("rx_parity", {31'd0, line_b}, {31'd0, (^d) ^ pt});
                end
                repeat (CB) step_b();
                chk("rx_stop_bit", {31'd0, line_b}, 32'd1);
            end
            for (int t = 0; t < 4 * CB && ib.busy; t++) step_b();
            chk("rx_busy_drop", {31'd0, ib.busy}, 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
